// File: rtl/wash_sequencer.sv
// Washing-machine program sequencer: fill, alternating wash, drain and spin,
// with level timeouts latched into a sticky FAULT state.
module wash_sequencer #(
  parameter int CNT_W         = 16,
  parameter int FILL_TIMEOUT  = 2000,
  parameter int WASH_TIME     = 6000,
  parameter int RUN_TIME      = 500,
  parameter int PAUSE_TIME    = 100,
  parameter int DRAIN_TIMEOUT = 2000,
  parameter int SPIN_TIME     = 3000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       level_full,
  input  logic       level_empty,
  output logic       ctrl_fill,
  output logic       ctrl_release,
  output logic       ctrl_forward,
  output logic       ctrl_reverse,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_FWD   = 3'd2,
    S_PAUSE = 3'd3,
    S_REV   = 3'd4,
    S_DRAIN = 3'd5,
    S_SPIN  = 3'd6,
    S_FAULT = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(FILL_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] WASH_LAST  = CNT_W'(WASH_TIME - 1);
  localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(RUN_TIME - 1);
  localparam logic [CNT_W-1:0] PAUSE_LAST = CNT_W'(PAUSE_TIME - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SPIN_LAST  = CNT_W'(SPIN_TIME - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] phase_cnt, wash_cnt;
  logic             last_rev;
  logic             aborted;
  logic             done_q, done_d;
  logic             abort_now;
  logic             in_wash;

  assign in_wash = (state_q == S_FWD) || (state_q == S_PAUSE) || (state_q == S_REV);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      phase_cnt <= '0;
      wash_cnt  <= '0;
      last_rev  <= 1'b0;
      aborted   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;

      if (state_d != state_q)
        phase_cnt <= '0;
      else if (state_q != S_IDLE && state_q != S_FAULT)
        phase_cnt <= phase_cnt + 1'b1;

      if (state_q == S_FILL && state_d == S_FWD)
        wash_cnt <= '0;
      else if (in_wash)
        wash_cnt <= wash_cnt + 1'b1;

      // Remembers the last run direction so PAUSE knows which way to go next.
      if (state_q == S_FWD)
        last_rev <= 1'b0;
      else if (state_q == S_REV)
        last_rev <= 1'b1;

      if (abort_now)
        aborted <= 1'b1;
      else if (state_d == S_IDLE)
        aborted <= 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    abort_now = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort)
          state_d = S_FILL;
      end
      S_FILL: begin
        if (abort) begin
          state_d   = S_DRAIN;
          abort_now = 1'b1;
        end else if (level_full)
          state_d = S_FWD;
        else if (phase_cnt == FILL_LAST)
          state_d = S_FAULT;
      end
      S_FWD, S_PAUSE, S_REV: begin
        // The overall wash limit outranks the run/pause cadence.
        if (abort) begin
          state_d   = S_DRAIN;
          abort_now = 1'b1;
        end else if (wash_cnt == WASH_LAST)
          state_d = S_DRAIN;
        else if (state_q == S_PAUSE) begin
          if (phase_cnt == PAUSE_LAST)
            state_d = last_rev ? S_FWD : S_REV;
        end else if (phase_cnt == RUN_LAST)
          state_d = S_PAUSE;
      end
      S_DRAIN: begin
        if (level_empty)
          state_d = aborted ? S_IDLE : S_SPIN;
        else if (phase_cnt == DRAIN_LAST)
          state_d = S_FAULT;
      end
      S_SPIN: begin
        if (abort)
          state_d = S_IDLE;
        else if (phase_cnt == SPIN_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ctrl_fill    = 1'b0;
    ctrl_release = 1'b0;
    ctrl_forward = 1'b0;
    ctrl_reverse = 1'b0;
    fault        = 1'b0;
    busy         = (state_q != S_IDLE) && (state_q != S_FAULT);
    done         = done_q;
    state        = state_q;
    case (state_q)
      S_FILL:  ctrl_fill    = 1'b1;
      S_FWD:   ctrl_forward = 1'b1;
      S_REV:   ctrl_reverse = 1'b1;
      S_DRAIN: ctrl_release = 1'b1;
      S_SPIN: begin
        ctrl_release = 1'b1;
        ctrl_forward = 1'b1;
      end
      S_FAULT: begin
        ctrl_release = 1'b1;
        fault        = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wash_sequencer.sv
// Scoreboard bench for wash_sequencer: expected state/output vectors are queued
// as each cycle's stimulus is driven and compared one cycle later.
module tb_wash_sequencer;

  localparam int FILL_TIMEOUT  = 20;
  localparam int WASH_TIME     = 50;
  localparam int RUN_TIME      = 8;
  localparam int PAUSE_TIME    = 3;
  localparam int DRAIN_TIMEOUT = 20;
  localparam int SPIN_TIME     = 10;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FILL  = 3'd1;
  localparam logic [2:0] ST_FWD   = 3'd2;
  localparam logic [2:0] ST_PAUSE = 3'd3;
  localparam logic [2:0] ST_REV   = 3'd4;
  localparam logic [2:0] ST_DRAIN = 3'd5;
  localparam logic [2:0] ST_SPIN  = 3'd6;
  localparam logic [2:0] ST_FAULT = 3'd7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       level_full = 1'b0;
  logic       level_empty = 1'b0;
  logic       ctrl_fill, ctrl_release, ctrl_forward, ctrl_reverse;
  logic       busy, done, fault;
  logic [2:0] state;

  int         vectors = 0;
  int         miscompares = 0;
  logic [9:0] exp_q[$];

  wash_sequencer #(
    .CNT_W(16), .FILL_TIMEOUT(FILL_TIMEOUT), .WASH_TIME(WASH_TIME),
    .RUN_TIME(RUN_TIME), .PAUSE_TIME(PAUSE_TIME),
    .DRAIN_TIMEOUT(DRAIN_TIMEOUT), .SPIN_TIME(SPIN_TIME)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .level_full(level_full), .level_empty(level_empty),
    .ctrl_fill(ctrl_fill), .ctrl_release(ctrl_release),
    .ctrl_forward(ctrl_forward), .ctrl_reverse(ctrl_reverse),
    .busy(busy), .done(done), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  // Vector layout: {state, fill, release, forward, reverse, busy, done, fault}.
  function automatic logic [9:0] expect_vec(input logic [2:0] s, input logic d);
    logic f, r, fw, rv, b, flt;
    f = 1'b0; r = 1'b0; fw = 1'b0; rv = 1'b0; flt = 1'b0;
    case (s)
      ST_FILL:  f = 1'b1;
      ST_FWD:   fw = 1'b1;
      ST_REV:   rv = 1'b1;
      ST_DRAIN: r = 1'b1;
      ST_SPIN:  begin r = 1'b1; fw = 1'b1; end
      ST_FAULT: begin r = 1'b1; flt = 1'b1; end
      default: ;
    endcase
    b = (s != ST_IDLE) && (s != ST_FAULT);
    return {s, f, r, fw, rv, b, d, flt};
  endfunction

  function automatic logic [2:0] wash_state(input int w);
    int p;
    p = w % (2 * (RUN_TIME + PAUSE_TIME));
    if (p < RUN_TIME)                       return ST_FWD;
    else if (p < RUN_TIME + PAUSE_TIME)     return ST_PAUSE;
    else if (p < 2 * RUN_TIME + PAUSE_TIME) return ST_REV;
    else                                    return ST_PAUSE;
  endfunction

  task automatic checkOutput(input string tag, input logic [9:0] actual, input logic [9:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %b, wanted %b", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic st, input logic ab,
                               input logic lf, input logic le, input logic r,
                               input logic [2:0] exp_s, input logic exp_d);
    logic [9:0] got;
    start = st; abort = ab; level_full = lf; level_empty = le; rst = r;
    exp_q.push_back(expect_vec(exp_s, exp_d));
    @(posedge clk);
    #1;
    got = {state, ctrl_fill, ctrl_release, ctrl_forward, ctrl_reverse, busy, done, fault};
    checkOutput(tag, got, exp_q.pop_front());
    checkOutput({tag, ".interlock"},
                {8'b0, ctrl_forward & ctrl_reverse, ctrl_fill & ctrl_release}, 10'b0);
  endtask

  task automatic wash_cycles(input string tag, input int from, input int to);
    for (int w = from; w <= to; w++)
      applyStimulus($sformatf("%s.wash%0d", tag, w), 0, 0, 0, 0, 0, wash_state(w), 0);
  endtask

  task automatic run_to_drain(input string tag);
    applyStimulus({tag, ".start"}, 1, 0, 0, 0, 0, ST_FILL, 0);
    applyStimulus({tag, ".full"}, 0, 0, 1, 0, 0, ST_FWD, 0);
    wash_cycles(tag, 1, WASH_TIME - 1);
    applyStimulus({tag, ".drain"}, 0, 0, 0, 0, 0, ST_DRAIN, 0);
  endtask

  initial begin
    applyStimulus("reset", 0, 0, 0, 0, 1, ST_IDLE, 0);
    applyStimulus("idle", 0, 0, 0, 0, 0, ST_IDLE, 0);

    // Normal program: five FILL cycles, full wash, four DRAIN cycles, spin.
    applyStimulus("norm.start", 1, 0, 0, 0, 0, ST_FILL, 0);
    for (int i = 2; i <= 5; i++)
      applyStimulus($sformatf("norm.fill%0d", i), 0, 0, 0, 0, 0, ST_FILL, 0);
    applyStimulus("norm.full", 0, 0, 1, 0, 0, ST_FWD, 0);
    wash_cycles("norm", 1, WASH_TIME - 1);
    applyStimulus("norm.drain1", 0, 0, 0, 0, 0, ST_DRAIN, 0);
    for (int i = 2; i <= 4; i++)
      applyStimulus($sformatf("norm.drain%0d", i), 0, 0, 0, 0, 0, ST_DRAIN, 0);
    applyStimulus("norm.empty", 0, 0, 0, 1, 0, ST_SPIN, 0);
    for (int i = 2; i <= SPIN_TIME; i++)
      applyStimulus($sformatf("norm.spin%0d", i), 0, 0, 0, 0, 0, ST_SPIN, 0);
    applyStimulus("norm.done", 0, 0, 0, 0, 0, ST_IDLE, 1);
    applyStimulus("norm.after", 0, 0, 0, 0, 0, ST_IDLE, 0);

    // Fill timeout and sticky FAULT.
    applyStimulus("fto.start", 1, 0, 0, 0, 0, ST_FILL, 0);
    for (int i = 2; i <= FILL_TIMEOUT; i++)
      applyStimulus($sformatf("fto.fill%0d", i), 0, 0, 0, 0, 0, ST_FILL, 0);
    applyStimulus("fto.fault", 0, 0, 0, 0, 0, ST_FAULT, 0);
    applyStimulus("fto.start_ign", 1, 0, 0, 0, 0, ST_FAULT, 0);
    applyStimulus("fto.abort_ign", 0, 1, 0, 0, 0, ST_FAULT, 0);
    applyStimulus("fto.hold", 0, 0, 1, 1, 0, ST_FAULT, 0);
    applyStimulus("fto.reset", 0, 0, 0, 0, 1, ST_IDLE, 0);

    // Abort during the second REV run.
    applyStimulus("abt.start", 1, 0, 0, 0, 0, ST_FILL, 0);
    applyStimulus("abt.full", 0, 0, 1, 0, 0, ST_FWD, 0);
    wash_cycles("abt", 1, 34);
    applyStimulus("abt.abort", 0, 1, 0, 0, 0, ST_DRAIN, 0);
    applyStimulus("abt.drain2", 0, 0, 0, 0, 0, ST_DRAIN, 0);
    applyStimulus("abt.drain3", 0, 1, 0, 0, 0, ST_DRAIN, 0);
    applyStimulus("abt.empty", 0, 0, 0, 1, 0, ST_IDLE, 0);
    applyStimulus("abt.after", 0, 0, 0, 0, 0, ST_IDLE, 0);

    // start+abort together in IDLE, then start while washing.
    applyStimulus("sa.both", 1, 1, 0, 0, 0, ST_IDLE, 0);
    applyStimulus("sa.start", 1, 0, 0, 0, 0, ST_FILL, 0);
    applyStimulus("sa.full", 0, 0, 1, 0, 0, ST_FWD, 0);
    for (int w = 1; w <= 12; w++)
      applyStimulus($sformatf("sa.wash%0d", w), (w == 2 || w == 9), 0, 0, 0, 0, wash_state(w), 0);
    applyStimulus("sa.reset", 0, 0, 0, 0, 1, ST_IDLE, 0);

    // Drain timeout.
    run_to_drain("dto");
    for (int i = 2; i <= DRAIN_TIMEOUT; i++)
      applyStimulus($sformatf("dto.drain%0d", i), 0, 0, 0, 0, 0, ST_DRAIN, 0);
    applyStimulus("dto.fault", 0, 0, 0, 0, 0, ST_FAULT, 0);
    applyStimulus("dto.reset", 0, 0, 0, 0, 1, ST_IDLE, 0);

    // Sensor arrives on the timeout cycle itself: normal transition wins.
    run_to_drain("dbd");
    for (int i = 2; i <= DRAIN_TIMEOUT; i++)
      applyStimulus($sformatf("dbd.drain%0d", i), 0, 0, 0, 0, 0, ST_DRAIN, 0);
    applyStimulus("dbd.empty_last", 0, 0, 0, 1, 0, ST_SPIN, 0);
    for (int i = 2; i <= 4; i++)
      applyStimulus($sformatf("dbd.spin%0d", i), 0, 0, 0, 0, 0, ST_SPIN, 0);

    // Reset mid-SPIN.
    applyStimulus("rspin.reset", 0, 0, 0, 0, 1, ST_IDLE, 0);
    applyStimulus("rspin.after", 0, 0, 0, 0, 0, ST_IDLE, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
